// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: channel states,
// ratio limits and the ratio clamp.
package clk_div_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_st_e;

  localparam int MIN_DIV     = 2;
  localparam int DEFAULT_DIV = 20;
  localparam int MAX_DIV_W   = 32;

  // Ratios below MIN_DIV cannot form a high and a low phase, so they are raised to MIN_DIV.
  function automatic logic [MAX_DIV_W-1:0] clamp_div(input logic [MAX_DIV_W-1:0] v);
    return (v < MAX_DIV_W'(MIN_DIV)) ? MAX_DIV_W'(MIN_DIV) : v;
  endfunction

endpackage

// File: rtl/clk_div_if.sv
// Control and status bundle for the multi-channel divider.
interface clk_div_if #(
  parameter int NCH   = 4,
  parameter int DIV_W = 8
);
  logic [NCH-1:0]       EN;
  logic [NCH-1:0]       DIV_LOAD;
  logic [NCH*DIV_W-1:0] DIV_VAL;
  logic                 SYNC;
  logic [NCH-1:0]       CLK_OUT;
  logic [NCH-1:0]       TICK;
  logic [NCH-1:0]       PEND;

  modport master (
    output EN, DIV_LOAD, DIV_VAL, SYNC,
    input  CLK_OUT, TICK, PEND
  );

  modport slave (
    input  EN, DIV_LOAD, DIV_VAL, SYNC,
    output CLK_OUT, TICK, PEND
  );
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: IDLE/RUN FSM, period counter, shadow ratio and active ratio.
// The shadow is only copied to the active ratio on a period boundary or while idle.
module clk_div_chan #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] val_i,
  input  logic             sync_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pend_o
);
  import clk_div_pkg::*;

  localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEF_DIV);

  chan_st_e         state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] nact_q, nact_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic [DIV_W:0]   hi;
  logic [DIV_W:0]   cnt_inc;
  logic             wrap;
  logic             apply;

  // One extra bit so ceil(N/2) cannot overflow at the maximum ratio.
  assign hi      = ({1'b0, nact_q} + (DIV_W+1)'(1)) >> 1;
  assign cnt_inc = {1'b0, cnt_q} + (DIV_W+1)'(1);
  assign wrap    = (cnt_q == nact_q - DIV_W'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en_i)  state_d = ST_RUN;
      ST_RUN:  if (!en_i) state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = '0;
    clk_d  = 1'b0;
    tick_d = 1'b0;
    apply  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        apply = 1'b1;
        if (en_i) begin
          clk_d  = 1'b1;
          tick_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          apply = 1'b0;
        end else if (sync_i || wrap) begin
          clk_d  = 1'b1;
          tick_d = 1'b1;
          apply  = 1'b1;
        end else begin
          cnt_d = cnt_inc[DIV_W-1:0];
          clk_d = (cnt_inc < hi);
        end
      end
      default: apply = 1'b0;
    endcase

    // The applied ratio is the pre-edge shadow, so a coincident load stays pending.
    shadow_d = load_i ? DIV_W'(clamp_div(MAX_DIV_W'(val_i))) : shadow_q;
    nact_d   = apply ? shadow_q : nact_q;
    pend_d   = load_i ? 1'b1 : (apply ? 1'b0 : pend_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      shadow_q <= DEF_N;
      nact_q   <= DEF_N;
      pend_q   <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      nact_q   <= nact_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: NCH independent channels sharing
// the system clock and a global phase-restart strobe.
module clk_div_prog #(
  parameter int NCH     = 4,
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = clk_div_pkg::DEFAULT_DIV
) (
  input  logic     F10MB,
  input  logic     RESET,
  clk_div_if.slave bus
);

  logic [NCH-1:0] clk_w;
  logic [NCH-1:0] tick_w;
  logic [NCH-1:0] pend_w;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk_i  (F10MB),
      .rst_i  (RESET),
      .en_i   (bus.EN[i]),
      .load_i (bus.DIV_LOAD[i]),
      .val_i  (bus.DIV_VAL[i*DIV_W +: DIV_W]),
      .sync_i (bus.SYNC),
      .clk_o  (clk_w[i]),
      .tick_o (tick_w[i]),
      .pend_o (pend_w[i])
    );
  end

  assign bus.CLK_OUT = clk_w;
  assign bus.TICK    = tick_w;
  assign bus.PEND    = pend_w;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: a ratio table per channel plus hand-written
// sequences for ratio changes, EN/SYNC behaviour and asynchronous reset.
module tb_clk_div_prog;
  localparam int NCH   = 4;
  localparam int DIV_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clk_div_if #(.NCH(NCH), .DIV_W(DIV_W)) bus ();

  clk_div_prog #(.NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(20)) dut (
    .F10MB (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    int ch;
    bit ld;
    int val;
    int per;
    int hi;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.EN       = '0;
    bus.DIV_LOAD = '0;
    bus.DIV_VAL  = '0;
    bus.SYNC     = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic load(input int c, input int v);
    bus.DIV_LOAD[c]              = 1'b1;
    bus.DIV_VAL[c*DIV_W +: DIV_W] = v[DIV_W-1:0];
    step();
    bus.DIV_LOAD[c] = 1'b0;
  endtask

  task automatic wait_tick(input int c, input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      step();
      if (bus.TICK[c]) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int c, h, t, hl, oth, bad, n;
    vecs[0] = '{0, 1'b0, 0,   20,  10};
    vecs[1] = '{1, 1'b1, 5,   5,   3};
    vecs[2] = '{2, 1'b1, 0,   2,   1};
    vecs[3] = '{3, 1'b1, 1,   2,   1};
    vecs[4] = '{0, 1'b1, 7,   7,   4};
    vecs[5] = '{1, 1'b1, 255, 255, 128};
    vecs[6] = '{2, 1'b1, 2,   2,   1};
    vecs[7] = '{3, 1'b1, 3,   3,   2};
    vecs[8] = '{0, 1'b1, 6,   6,   3};

    // Reset state
    do_reset();
    check("rst_clk",  int'(bus.CLK_OUT), 0);
    check("rst_tick", int'(bus.TICK), 0);
    check("rst_pend", int'(bus.PEND), 0);

    // Ratio table
    for (int i = 0; i < 9; i++) begin
      do_reset();
      c = vecs[i].ch;
      if (vecs[i].ld) begin
        load(c, vecs[i].val);
        check("pend_set", int'(bus.PEND[c]), 1);
        step();
        check("pend_clr", int'(bus.PEND[c]), 0);
      end
      bus.EN[c] = 1'b1;
      step();
      check("first_rise", int'(bus.CLK_OUT[c] && bus.TICK[c]), 1);
      h = 0; t = 0; hl = -1; oth = 0;
      for (int k = 0; k < 2 * vecs[i].per; k++) begin
        if (k > 0) step();
        if (bus.CLK_OUT[c]) h++;
        if (bus.TICK[c]) t++;
        if (hl < 0 && !bus.CLK_OUT[c]) hl = k;
        if ((bus.CLK_OUT & ~(4'(1) << c)) != '0) oth = 1;
      end
      check("hi_len", hl, vecs[i].hi);
      check("hi_total", h, 2 * vecs[i].hi);
      check("ticks", t, 2);
      check("others_idle", oth, 0);
      step();
      check("tick_period", int'(bus.TICK[c]), 1);
      bus.EN = '0;
    end

    // Glitch-free ratio change mid-period
    do_reset();
    bus.EN[0] = 1'b1;
    step();
    repeat (7) step();
    load(0, 4);
    check("chg_pend", int'(bus.PEND[0]), 1);
    bad = 0;
    for (int k = 8; k <= 19; k++) begin
      if (k > 8) step();
      if (bus.CLK_OUT[0] != (k < 10)) bad++;
      if (bus.TICK[0]) bad++;
    end
    check("chg_old_period", bad, 0);
    check("chg_pend_hold", int'(bus.PEND[0]), 1);
    step();
    check("chg_wrap_tick", int'(bus.TICK[0]), 1);
    check("chg_pend_drop", int'(bus.PEND[0]), 0);
    bad = 0;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) step();
      if (bus.CLK_OUT[0] != (k < 2)) bad++;
    end
    check("chg_new_shape", bad, 0);
    load(0, 6);
    check("coinc_tick", int'(bus.TICK[0]), 1);
    check("coinc_pend", int'(bus.PEND[0]), 1);
    wait_tick(0, 10, n);
    check("coinc_old_per", n, 4);
    check("coinc_pend_clr", int'(bus.PEND[0]), 0);
    wait_tick(0, 20, n);
    check("coinc_new_per", n, 6);

    // EN drop while high
    do_reset();
    bus.EN[0] = 1'b1;
    step();
    repeat (3) step();
    check("endrop_pre", int'(bus.CLK_OUT[0]), 1);
    bus.EN[0] = 1'b0;
    step();
    check("endrop_clk", int'(bus.CLK_OUT[0]), 0);
    check("endrop_tick", int'(bus.TICK[0]), 0);
    bad = 0;
    repeat (5) begin
      step();
      if (bus.CLK_OUT[0] || bus.TICK[0]) bad++;
    end
    check("endrop_stay", bad, 0);

    // SYNC aligns ch0 (N=20, cnt=13) and ch2 (N=6, cnt=4); ch1 stays idle
    do_reset();
    load(2, 6);
    step();
    bus.EN[0] = 1'b1;
    step();
    repeat (8) step();
    bus.EN[2] = 1'b1;
    step();
    repeat (4) step();
    check("sync_pre", int'({bus.CLK_OUT[2], bus.CLK_OUT[0]}), 0);
    bus.SYNC = 1'b1;
    step();
    bus.SYNC = 1'b0;
    check("sync_tick", int'({bus.TICK[2], bus.TICK[0]}), 3);
    check("sync_clk", int'({bus.CLK_OUT[2], bus.CLK_OUT[0]}), 3);
    check("sync_idle_ch1", int'(bus.CLK_OUT[1] | bus.TICK[1]), 0);
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (bus.TICK[0] && bus.TICK[2]) n++;
    end
    check("sync_coinc", n, 1);
    check("sync_60", int'(bus.TICK[0] && bus.TICK[2]), 1);

    // Asynchronous reset between edges
    do_reset();
    bus.EN[0] = 1'b1;
    step();
    step();
    load(0, 9);
    check("arst_pre", int'({bus.PEND[0], bus.CLK_OUT[0]}), 3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_clk", int'(bus.CLK_OUT), 0);
    check("arst_tick", int'(bus.TICK), 0);
    check("arst_pend", int'(bus.PEND), 0);
    #2;
    rst = 1'b0;
    step();
    check("arst_restart", int'(bus.TICK[0]), 1);
    wait_tick(0, 40, n);
    check("arst_ratio", n, 20);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Multi-channel programmable clock divider. It is the parametrised successor of the fixed 10 MHz→500 kHz divider. Each of NCH channels divides the system clock F10MB by a run-time ratio N, loaded through a shadow register and applied glitch-free at the period boundary. Outputs are registered divided clocks plus one-cycle period strobes, used as enables or slow clocks by downstream timing logic. A global SYNC input phase-aligns all running channels.

Parameters:
NCH, 4, number of independent divider channels (≥1)
DIV_W, 8, width of each divide ratio
DEF_DIV, 20, reset value of every channel's ratio (2 ≤ DEF_DIV < 2^DIV_W)

Ports:
F10MB  in  1  system clock; all logic on rising edge
RESET  in  1  asynchronous, active-high reset
EN  in  NCH  per-channel run enable, level
DIV_LOAD  in  NCH  per-channel one-cycle load strobe
DIV_VAL  in  NCH*DIV_W  ratio for channel i at bits [i*DIV_W +: DIV_W]
SYNC  in  1  one-cycle strobe; restarts phase of all running channels
CLK_OUT  out  NCH  divided clock per channel, registered
TICK  out  NCH  one-cycle pulse on the cycle CLK_OUT rises (period start)
PEND  out  NCH  shadow ratio loaded but not yet active

Behaviour:
- One clock domain: F10MB. RESET is asynchronous and active-high.
- While RESET is high, all outputs go to 0 immediately, without waiting for a clock edge. Per-channel state: IDLE, cnt=0, shadow=DEF_DIV, N_act=DEF_DIV, PEND=0.
- Load:
  - DIV_LOAD[i]=1 → shadow[i] <= clamp(DIV_VAL slice), where clamp maps 0 and 1 to 2.
  - PEND[i] <= 1.
  - A later load before application overwrites the shadow; last write wins.
- Application of the shadow value:
  - N_act <= shadow and PEND <= 0 on the same edge as a wrap, a SYNC restart, an IDLE→RUN start, or any IDLE cycle.
  - The value applied is the shadow as it was before that edge. A load coincident with an apply edge stays pending until the next apply.
- Duty cycle: HI = ceil(N_act/2).
  - CLK_OUT is high for HI cycles and low for N_act−HI cycles.
  - Even N gives 50% duty. Odd N gives (N+1)/2 high and (N−1)/2 low.
- Per-channel FSM, priority EN=0 > SYNC > wrap:
  - IDLE: cnt=0, CLK_OUT=0, TICK=0. If EN=1 at the edge → RUN, cnt<=0, CLK_OUT<=1, TICK<=1, N_act<=shadow.
  - RUN, EN=0 → IDLE, CLK_OUT<=0, cnt<=0, TICK<=0. The output truncates cleanly; no runt pulse is generated.
  - RUN, SYNC=1 → cnt<=0, CLK_OUT<=1, TICK<=1, apply shadow.
  - RUN, cnt==N_act−1 (wrap) → cnt<=0, CLK_OUT<=1, TICK<=1, apply shadow.
  - RUN, otherwise → cnt<=cnt+1, CLK_OUT<=(cnt+1 < HI), TICK<=0.
- Latency:
  - First CLK_OUT/TICK high is 1 cycle after EN is sampled high.
  - Period = N_act cycles exactly.
  - TICK period = N_act.
- SYNC has no effect on IDLE channels.
- Channels are fully independent except for SYNC.
- cnt and N_act are DIV_W bits wide. Maximum ratio is 2^DIV_W−1; no overflow is possible.

Decomposition:
- Shared package clk_div_pkg holds:
  - FSM state encoding (IDLE/RUN)
  - MIN_DIV=2
  - a clamp function for the ratio
  - the DEF_DIV default constant
- Natural sub-module: clk_div_chan, a single channel containing its FSM, counter, shadow and N_act. The top module instantiates NCH copies via a generate loop, slices DIV_VAL, and fans out SYNC.

Test Plan:
- Default ratio: release RESET, EN[0]=1 → CLK_OUT[0] goes high 1 cycle later, then holds 10 high / 10 low repeatedly; TICK[0] pulses every 20 cycles; other channels stay 0.
- Odd ratio: load N=5 on ch1 while IDLE, then EN[1]=1 → 3 high / 2 low, TICK every 5 cycles; PEND[1] clears 1 cycle after the load.
- Glitch-free change: ch0 running N=20, load N=4 at cnt=7 → PEND=1, current 20-cycle period completes unchanged, then 2 high / 2 low; PEND drops on the wrap edge. Load coincident with a wrap is applied one period later.
- Clamp: load DIV_VAL=0, then 1 → channel toggles every cycle (N=2), TICK on every rising edge.
- EN/SYNC: drop EN mid-high → CLK_OUT 0 next edge. SYNC while ch0 (N=20, cnt=13) and ch2 (N=6, cnt=4) run → both rise with TICK on the next edge and stay aligned every 60 cycles.
- Async reset: assert RESET between clock edges mid-run → CLK_OUT/TICK/PEND are 0 before the next edge; after release the ratio is back to 20.
